// File: rtl/frame_writer.sv
// rtl/frame_writer.sv - streams or fills one raster frame into a 12-bit frame buffer
// Write address is {x,y}; each write appears one cycle after the beat or fill step.
module frame_writer #(
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic        clk_div,
  input  logic        rst,
  input  logic        start,
  input  logic        fill,
  input  logic [11:0] fill_color,
  input  logic [23:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic [18:0] wr_addr,
  output logic [11:0] wr_data,
  output logic        wr_en,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, LOAD, FILL, DONE} state_t;

  localparam logic [9:0] X_LAST = 10'(H_RES - 1);
  localparam logic [8:0] Y_LAST = 9'(V_RES - 1);

  state_t      state;
  logic [9:0]  x;
  logic [8:0]  y;
  logic [11:0] color;

  logic        step_px;
  logic        last_px;
  logic [11:0] src_rgb;
  logic        unused_pix;

  // Only the top nibble of each 8-bit channel reaches the buffer.
  assign src_rgb    = {pix_data[23:20], pix_data[15:12], pix_data[7:4]};
  assign unused_pix = ^{pix_data[19:16], pix_data[11:8], pix_data[3:0]};

  assign pix_ready = (state == LOAD);
  assign busy      = (state == LOAD) || (state == FILL);
  assign step_px   = (state == FILL) || ((state == LOAD) && pix_valid);
  assign last_px   = (x == X_LAST) && (y == Y_LAST);

  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      x       <= '0;
      y       <= '0;
      color   <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      done    <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          x <= '0;
          y <= '0;
          if (start) begin
            state <= LOAD;
          end else if (fill) begin
            state <= FILL;
            color <= fill_color;
          end
        end
        LOAD, FILL: begin
          if (step_px) begin
            wr_en   <= 1'b1;
            wr_addr <= {x, y};
            wr_data <= (state == FILL) ? color : src_rgb;
            if (last_px) begin
              state <= DONE;
              done  <= 1'b1;
              x     <= '0;
              y     <= '0;
            end else if (x == X_LAST) begin
              x <= '0;
              y <= y + 9'd1;
            end else begin
              x <= x + 10'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_writer.sv
// tb/tb_frame_writer.sv - randomized bench for frame_writer against a write-index reference model
// The model numbers writes n = 0..H*V-1 and derives the address as {n % H, n / H}.
module tb_frame_writer;

  localparam int H = 640;
  localparam int V = 4;
  localparam int N = H * V;

  logic        clk_div = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        fill = 1'b0;
  logic [11:0] fill_color = '0;
  logic [23:0] pix_data = '0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [18:0] wr_addr;
  logic [11:0] wr_data;
  logic        wr_en;
  logic        busy;
  logic        done;

  frame_writer #(.H_RES(H), .V_RES(V)) dut (
    .clk_div    (clk_div),
    .rst        (rst),
    .start      (start),
    .fill       (fill),
    .fill_color (fill_color),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_en      (wr_en),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk_div = ~clk_div;

  int checks = 0;
  int errors = 0;

  // model: 0 idle, 1 load, 2 fill, 3 done
  int          m_state;
  int          m_n;
  logic        m_wr_en;
  logic [18:0] m_addr;
  logic [11:0] m_data;
  logic [11:0] m_color;

  int          f_writes;
  int          f_dones;
  int          f_first;
  int          f_last;
  int          cyc;
  logic [18:0] obs_addr[$];
  logic [11:0] obs_data[$];

  function automatic logic [18:0] addr_of(input int n);
    return {10'(n % H), 9'(n / H)};
  endfunction

  function automatic logic [11:0] rgb12(input logic [23:0] p);
    return {p[23:20], p[15:12], p[7:4]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_n     = 0;
    m_wr_en = 1'b0;
    m_addr  = '0;
    m_data  = '0;
    m_color = '0;
  endtask

  task automatic frame_begin();
    f_writes = 0;
    f_dones  = 0;
    f_first  = 0;
    f_last   = 0;
    cyc      = 0;
    obs_addr.delete();
    obs_data.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_en"},     32'(wr_en),     32'd0);
    check({tag, "_wr_addr"},   32'(wr_addr),   32'd0);
    check({tag, "_wr_data"},   32'(wr_data),   32'd0);
    check({tag, "_done"},      32'(done),      32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_pix_ready"}, 32'(pix_ready), 32'd0);
  endtask

  // Called at a falling edge: drive, check state-level outputs, advance model, check write port.
  task automatic step(input logic s, input logic f, input logic [11:0] fc,
                      input logic v, input logic [23:0] pd);
    start      = s;
    fill       = f;
    fill_color = fc;
    pix_valid  = v;
    pix_data   = pd;
    #1;
    check("pix_ready", 32'(pix_ready), 32'(m_state == 1));
    check("busy",      32'(busy),      32'(m_state == 1 || m_state == 2));
    check("done",      32'(done),      32'(m_state == 3));
    if (done) f_dones++;
    m_wr_en = 1'b0;
    case (m_state)
      0: begin
        if (s) begin
          m_state = 1;
          m_n     = 0;
        end else if (f) begin
          m_state = 2;
          m_n     = 0;
          m_color = fc;
        end
      end
      1, 2: begin
        if (m_state == 2 || v) begin
          m_wr_en = 1'b1;
          m_addr  = addr_of(m_n);
          m_data  = (m_state == 2) ? m_color : rgb12(pd);
          m_n++;
          if (m_n == N) m_state = 3;
        end
      end
      default: m_state = 0;
    endcase
    @(posedge clk_div);
    @(negedge clk_div);
    cyc++;
    check("wr_en",   32'(wr_en),   32'(m_wr_en));
    check("wr_addr", 32'(wr_addr), 32'(m_addr));
    check("wr_data", 32'(wr_data), 32'(m_data));
    if (wr_en) begin
      f_writes++;
      if (f_writes == 1) f_first = cyc;
      f_last = cyc;
      obs_addr.push_back(wr_addr);
      obs_data.push_back(wr_data);
    end
  endtask

  task automatic run_frame(input int duty, input bit fixed, input bit poke);
    int guard;
    logic v;
    logic s;
    logic f;
    logic [23:0] pd;
    guard = 0;
    while (m_state != 0 && guard < 4 * N + 50) begin
      v  = ($urandom_range(99) < duty);
      pd = fixed ? 24'hABCDEF : 24'($urandom);
      s  = poke && ($urandom_range(15) == 0);
      f  = poke && ($urandom_range(15) == 0);
      step(s, f, 12'($urandom), v, pd);
      guard++;
    end
    check("frame_timeout", 32'(m_state), 32'd0);
    check("frame_writes",  32'(f_writes), 32'(N));
    check("frame_dones",   32'(f_dones),  32'd1);
  endtask

  initial begin
    int bad;
    int guard;
    model_reset();
    frame_begin();

    #1 rst = 1'b1;
    #2 check_all_zero("reset");
    @(negedge clk_div);
    @(negedge clk_div);
    rst = 1'b0;

    // gap-free load of a constant pixel
    frame_begin();
    step(1'b1, 1'b0, 12'h000, 1'b1, 24'hABCDEF);
    run_frame(100, 1'b1, 1'b0);
    if (obs_addr.size() == N) begin
      check("first_addr",  32'(obs_addr[0]),     32'd0);
      check("first_data",  32'(obs_data[0]),     32'h0ACE);
      check("wrap_639",    32'(obs_addr[639]),   32'({10'd639, 9'd0}));
      check("wrap_640",    32'(obs_addr[640]),   32'({10'd0, 9'd1}));
      check("last_addr",   32'(obs_addr[N - 1]), 32'({10'd639, 9'(V - 1)}));
    end
    check("first_write_cycle", 32'(f_first), 32'd2);
    check("gapfree_span",      32'(f_last - f_first + 1), 32'(N));

    // ~50% valid gaps, random data, stray start/fill during LOAD
    frame_begin();
    step(1'b1, 1'b0, 12'h000, 1'b1, 24'h123456);
    run_frame(50, 1'b0, 1'b1);
    if (obs_addr.size() == N) begin
      check("gap_last_addr", 32'(obs_addr[N - 1]), 32'({10'd639, 9'(V - 1)}));
    end

    // start and fill together: start wins
    frame_begin();
    step(1'b1, 1'b1, 12'h0F0, 1'b0, 24'h0);
    check("simul_ready", 32'(pix_ready), 32'd1);
    run_frame(70, 1'b0, 1'b1);

    // fill-only run with start pokes during FILL
    frame_begin();
    step(1'b0, 1'b1, 12'h0F0, 1'b0, 24'h0);
    run_frame(30, 1'b0, 1'b1);
    check("fill_span", 32'(f_last - f_first + 1), 32'(N));
    bad = 0;
    foreach (obs_data[i]) if (obs_data[i] !== 12'h0F0) bad++;
    check("fill_data_all", 32'(bad), 32'd0);

    // reset after 1000 writes of a LOAD
    frame_begin();
    step(1'b1, 1'b0, 12'h000, 1'b0, 24'h0);
    guard = 0;
    while (f_writes < 1000 && guard < 5000) begin
      step(1'b0, 1'b0, 12'h000, 1'($urandom_range(1)), 24'($urandom));
      guard++;
    end
    check("pre_reset_writes", 32'(f_writes), 32'd1000);
    rst = 1'b1;
    #1 check_all_zero("midreset");
    @(posedge clk_div);
    #1 check_all_zero("midreset_hold");
    @(negedge clk_div);
    rst = 1'b0;
    check("midreset_dones", 32'(f_dones), 32'd0);
    model_reset();

    frame_begin();
    step(1'b1, 1'b0, 12'h000, 1'b1, 24'h0);
    run_frame(80, 1'b0, 1'b0);
    if (obs_addr.size() > 0) check("restart_first_addr", 32'(obs_addr[0]), 32'd0);
    else check("restart_has_writes", 32'(obs_addr.size()), 32'(N));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
